// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus slave.
package mem_bus_ctrl_pkg;
    localparam int   WAIT_W = 4;
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/mem_bus_ctrl_mem_array.sv
// Word-addressed 32-bit RAM: one write port and a registered read port.
module mem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus slave: latches a request, waits WAIT_CYCLES, accesses RAM,
// then holds memOpDone until the CPU drops memReq.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memReq,
    input  logic        memRWPin,
    input  logic [31:0] addressBus,
    inout  wire  [31:0] dataBus,
    output logic        memOpDone,
    output logic        memErr
);
    localparam logic [32:0] SPAN = 33'd4 << ADDR_W;

    state_t            state, state_n;
    logic [WAIT_W-1:0] cnt;
    logic [31:0]       addr_q, wdata_q, offset, ram_rdata;
    logic              rw_q, acc_err, ram_we, ram_re;

    // Range is judged on the unsigned offset before it is used as an index.
    assign offset  = addr_q - BASE_ADDR;
    assign acc_err = (addr_q[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign ram_we  = (state == S_ACCESS) && (rw_q == MEM_WR) && !acc_err;
    assign ram_re  = (state == S_ACCESS) && (rw_q == MEM_RD);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (memReq) state_n = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt == WAIT_W'(1)) state_n = S_ACCESS;
            S_ACCESS: state_n = S_DONE;
            S_DONE:   if (!memReq) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            memErr  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= MEM_RD;
        end else begin
            case (state)
                S_IDLE: if (memReq) begin
                    addr_q  <= addressBus;
                    rw_q    <= memRWPin;
                    wdata_q <= dataBus;
                    cnt     <= WAIT_W'(WAIT_CYCLES);
                end
                S_WAIT:   cnt <= cnt - 1'b1;
                S_ACCESS: memErr <= acc_err;
                S_DONE:   if (!memReq) memErr <= 1'b0;
                default:  ;
            endcase
        end
    end

    mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (offset[ADDR_W+1:2]),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (offset[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    assign memOpDone = (state == S_DONE);
    // An erroring read returns zero rather than whatever the RAM port holds.
    assign dataBus = (state == S_DONE && rw_q == MEM_RD) ? (memErr ? 32'h0 : ram_rdata) : 'z;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench: one DUT with two wait states, one with none.
module tb_mem_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, rw = 1'b0, drv = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wd = '0;
    wire  [31:0] bus2, bus0;
    logic        done2, done0, err2, err0;
    int          pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    assign bus2 = drv ? wd : 'z;
    assign bus0 = drv ? wd : 'z;

    mem_bus_ctrl #(.ADDR_W(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .memReq(req & ~sel), .memRWPin(rw),
        .addressBus(addr), .dataBus(bus2), .memOpDone(done2), .memErr(err2));

    mem_bus_ctrl #(.ADDR_W(8), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .memReq(req & sel), .memRWPin(rw),
        .addressBus(addr), .dataBus(bus0), .memOpDone(done0), .memErr(err0));

    wire        done = sel ? done0 : done2;
    wire        err  = sel ? err0  : err2;
    wire [31:0] bus  = sel ? bus0  : bus2;

    // Raise a request and count edges (E0 = 1) until memOpDone; -1 on timeout.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit tog, output int lat);
        @(posedge clk); #1;
        req = 1'b1; rw = w; addr = a; wd = d; drv = w;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) return;
            if (tog) begin
                addr = addr ^ 32'h0000_0004;
                wd   = ~wd;
                rw   = ~rw;
            end
        end
        lat = -1;
    endtask

    task automatic release_req();
        req = 1'b0; drv = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (done2 !== 1'b0) $display("FAIL reset_done got=%b exp=0", done2); else pass_cnt++;
        total++; if (err2 !== 1'b0) $display("FAIL reset_err got=%b exp=0", err2); else pass_cnt++;
        total++; if (done0 !== 1'b0) $display("FAIL reset_done0 got=%b exp=0", done0); else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat;
        sel = 1'b0;
        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat);
        total++; if (lat !== 4) $display("FAIL wr_latency got=%0d exp=4", lat); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL wr_err got=%b exp=0", err); else pass_cnt++;
        release_req();
        total++; if (done !== 1'b0) $display("FAIL wr_drop_done got=%b exp=0", done); else pass_cnt++;
        access(1'b0, 32'h10, 32'h0, 1'b0, lat);
        total++; if (lat !== 4) $display("FAIL rd_latency got=%0d exp=4", lat); else pass_cnt++;
        total++; if (bus !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", bus); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL rd_err got=%b exp=0", err); else pass_cnt++;
        // memReq held high: done must stay asserted without a restart
        @(posedge clk); #1;
        total++; if (done !== 1'b1) $display("FAIL rd_hold_done got=%b exp=1", done); else pass_cnt++;
        release_req();
    endtask

    task automatic test_zero_wait();
        int lat;
        sel = 1'b1;
        access(1'b1, 32'h0, 32'h5A5A0F0F, 1'b0, lat);
        total++; if (lat !== 2) $display("FAIL w0_wr_latency got=%0d exp=2", lat); else pass_cnt++;
        release_req();
        access(1'b0, 32'h0, 32'h0, 1'b0, lat);
        total++; if (lat !== 2) $display("FAIL w0_rd_latency got=%0d exp=2", lat); else pass_cnt++;
        total++; if (bus !== 32'h5A5A0F0F) $display("FAIL w0_rd_data got=%h exp=5a5a0f0f", bus); else pass_cnt++;
        release_req();
        total++; if (done !== 1'b0) $display("FAIL w0_drop_done got=%b exp=0", done); else pass_cnt++;
        // With the DUT released, the bench's own zero drive must read back unaltered.
        drv = 1'b1; wd = 32'h0; #1;
        total++; if (bus !== 32'h0) $display("FAIL w0_bus_release got=%h exp=00000000", bus); else pass_cnt++;
        drv = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_misaligned();
        int lat;
        access(1'b1, 32'h12, 32'h1234, 1'b0, lat);
        total++; if (lat !== 4) $display("FAIL mis_latency got=%0d exp=4", lat); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL mis_err got=%b exp=1", err); else pass_cnt++;
        release_req();
        total++; if (err !== 1'b0) $display("FAIL mis_err_clear got=%b exp=0", err); else pass_cnt++;
        access(1'b0, 32'h10, 32'h0, 1'b0, lat);
        total++; if (bus !== 32'hDEADBEEF) $display("FAIL mis_keep got=%h exp=deadbeef", bus); else pass_cnt++;
        release_req();
    endtask

    task automatic test_range();
        int lat;
        access(1'b0, 32'h400, 32'h0, 1'b0, lat);
        total++; if (err !== 1'b1) $display("FAIL oor_err got=%b exp=1", err); else pass_cnt++;
        total++; if (bus !== 32'h0) $display("FAIL oor_data got=%h exp=00000000", bus); else pass_cnt++;
        release_req();
        access(1'b0, 32'h3FC, 32'h0, 1'b0, lat);
        total++; if (lat !== 4) $display("FAIL top_latency got=%0d exp=4", lat); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL top_err got=%b exp=0", err); else pass_cnt++;
        release_req();
    endtask

    task automatic test_latch_once();
        int lat;
        access(1'b1, 32'h20, 32'hCAFEF00D, 1'b1, lat);
        total++; if (lat !== 4) $display("FAIL tog_latency got=%0d exp=4", lat); else pass_cnt++;
        release_req();
        access(1'b0, 32'h20, 32'h0, 1'b0, lat);
        total++; if (bus !== 32'hCAFEF00D) $display("FAIL tog_data got=%h exp=cafef00d", bus); else pass_cnt++;
        release_req();
    endtask

    task automatic test_reset_abort();
        int lat;
        access(1'b1, 32'h24, 32'h11112222, 1'b0, lat);
        release_req();
        @(posedge clk); #1;
        req = 1'b1; rw = 1'b1; addr = 32'h24; wd = 32'h99999999; drv = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0; drv = 1'b0;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL abort_err got=%b exp=0", err); else pass_cnt++;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL abort_idle got=%b exp=0", done); else pass_cnt++;
        access(1'b0, 32'h24, 32'h0, 1'b0, lat);
        total++; if (bus !== 32'h11112222) $display("FAIL abort_old got=%h exp=11112222", bus); else pass_cnt++;
        release_req();
        drv = 1'b1; wd = 32'h0; #1;
        total++; if (bus !== 32'h0) $display("FAIL abort_bus_release got=%h exp=00000000", bus); else pass_cnt++;
        drv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_misaligned();
        test_range();
        test_latch_once();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
